// File: rtl/rgb_seq_pkg.sv
// rgb_seq_pkg: shared types and constants for the RGB colour sequencer.
// Holds the FSM state enum, the register map, the CTRL/STATUS bit positions
// and the colour codes that the downstream LED driver understands.
package rgb_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    // Register map (4-bit word address)
    localparam logic [3:0] ADDR_CTRL       = 4'd0;
    localparam logic [3:0] ADDR_STATUS     = 4'd1;
    localparam logic [3:0] ADDR_ENTRY_BASE = 4'd8;

    // CTRL bit positions
    localparam int CTRL_RUN_BIT  = 0;
    localparam int CTRL_LOOP_BIT = 1;
    localparam int CTRL_LAST_LSB = 4;

    // STATUS bit positions
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_IDX_LSB  = 4;
    localparam int STATUS_DONE_BIT = 8;

    // ENTRY field positions
    localparam int ENTRY_COLOR_LSB = 0;
    localparam int ENTRY_HOLD_LSB  = 8;

    // Colour codes, identical to the LED driver encoding
    localparam logic [2:0] OFF      = 3'd0;
    localparam logic [2:0] ROJO     = 3'd1;
    localparam logic [2:0] VERDE    = 3'd2;
    localparam logic [2:0] AZUL     = 3'd3;
    localparam logic [2:0] AMARILLO = 3'd4;
    localparam logic [2:0] CIAN     = 3'd5;
    localparam logic [2:0] MAGENTA  = 3'd6;
    localparam logic [2:0] BLANCO   = 3'd7;

    // One sequence step as stored in the entry file
    typedef struct packed {
        logic [7:0] hold;
        logic [2:0] color;
    } entry_t;

    // A programmed hold of zero ticks behaves like one tick.
    function automatic logic [7:0] hold_load(input logic [7:0] h);
        return (h == 8'd0) ? 8'd1 : h;
    endfunction

endpackage

// File: rtl/module_rgb_sequencer_prescaler.sv
// module_tick_prescaler: divides clk_i down to a one-cycle tick.
// Latency: tick_o first pulses TICK_DIV cycles after clr_i drops, then every TICK_DIV cycles.
// Backpressure: none; free-running counter, clr_i holds it at zero.
// Ports: clk_i clock, rst_i sync active-high reset, clr_i sync clear, tick_o tick pulse.
module module_tick_prescaler #(
    parameter int TICK_DIV = 10000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/module_rgb_sequencer.sv
// module_rgb_sequencer: memory-mapped sequencer that plays up to 8 (colour, hold) steps
// into the RGB LED driver. Latency: CTRL write at edge T -> colour strobe at edge T+2;
// reads return one cycle after the address is sampled. Backpressure: none; the LED driver
// always accepts color_we_o, bus writes are always accepted.
// Ports: clk_i, rst_i (sync, active-high), we_i/addr_i/data_i bus write, data_o registered
// read data, color_o/color_we_o to the LED driver.
// Build option: define RGB_SEQ_READBACK_EN to make ENTRY registers readable at addr 8-15;
// without it those addresses read as 0 and only CTRL/STATUS are readable.
module module_rgb_sequencer
    import rgb_seq_pkg::*;
#(
    parameter int TICK_DIV = 10000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic [2:0]  color_o,
    output logic        color_we_o
);

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic       ctrl_run_q;
    logic       ctrl_loop_q;
    logic [2:0] ctrl_last_q;
    logic       cmd_q;          // CTRL was written at the previous edge
    entry_t     entry_q [8];

    logic ctrl_wr;
    logic entry_wr;

    assign ctrl_wr  = we_i && (addr_i == ADDR_CTRL);
    assign entry_wr = we_i && (addr_i[3] == ADDR_ENTRY_BASE[3]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_run_q  <= 1'b0;
            ctrl_loop_q <= 1'b0;
            ctrl_last_q <= 3'd0;
            cmd_q       <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            cmd_q <= ctrl_wr;
            if (ctrl_wr) begin
                ctrl_run_q  <= data_i[CTRL_RUN_BIT];
                ctrl_loop_q <= data_i[CTRL_LOOP_BIT];
                ctrl_last_q <= data_i[CTRL_LAST_LSB +: 3];
            end
            if (entry_wr) begin
                entry_q[addr_i[2:0]].color <= data_i[ENTRY_COLOR_LSB +: 3];
                entry_q[addr_i[2:0]].hold  <= data_i[ENTRY_HOLD_LSB +: 8];
            end
        end
    end

    // Bits of the write bus that no register field stores.
    logic unused_data_bits;
    assign unused_data_bits = ^{data_i[31:16], data_i[7], data_i[3]};

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] hold_q, hold_d;
    logic [2:0] color_d;
    logic       color_we_d;
    logic       off_pend_q, off_pend_d;
    logic       tick;
    logic       presc_clr;

    // The prescaler only runs while holding, so every HOLD starts from zero.
    assign presc_clr = (state_q != HOLD);

    module_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (presc_clr),
        .tick_o (tick)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        hold_d     = hold_q;
        color_d    = color_o;
        color_we_d = 1'b0;
        off_pend_d = off_pend_q;

        if (cmd_q) begin
            // A CTRL write outranks whatever the FSM would otherwise do this
            // cycle, including a LOAD strobe or a hold expiry.
            if (ctrl_run_q) begin
                state_d    = LOAD;
                idx_d      = 3'd0;
                off_pend_d = 1'b0;
            end else if (state_q != IDLE) begin
                state_d = IDLE;
                idx_d   = 3'd0;
                hold_d  = 8'd0;
                // If a colour strobe is on the wire right now, defer the
                // LED-off strobe one cycle so strobes never touch.
                if (color_we_o) begin
                    off_pend_d = 1'b1;
                end else begin
                    color_d    = OFF;
                    color_we_d = 1'b1;
                end
            end
        end else if (off_pend_q) begin
            // Only reachable in IDLE: leaving IDLE needs a run command, which
            // clears the pending flag.
            color_d    = OFF;
            color_we_d = 1'b1;
            off_pend_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                end
                LOAD: begin
                    color_d    = entry_q[idx_q].color;
                    color_we_d = 1'b1;
                    hold_d     = hold_load(entry_q[idx_q].hold);
                    state_d    = HOLD;
                end
                HOLD: begin
                    if (tick) begin
                        if (hold_q <= 8'd1) begin
                            hold_d = 8'd0;
                            if (idx_q != ctrl_last_q) begin
                                idx_d   = idx_q + 3'd1;
                                state_d = LOAD;
                            end else if (ctrl_loop_q) begin
                                idx_d   = 3'd0;
                                state_d = LOAD;
                            end else begin
                                state_d = DONE;
                            end
                        end else begin
                            hold_d = hold_q - 8'd1;
                        end
                    end
                end
                DONE: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            hold_q     <= 8'd0;
            color_o    <= OFF;
            color_we_o <= 1'b0;
            off_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hold_q     <= hold_d;
            color_o    <= color_d;
            color_we_o <= color_we_d;
            off_pend_q <= off_pend_d;
        end
    end

    // ------------------------------------------------------------------
    // Registered read port
    // ------------------------------------------------------------------
    logic [31:0] rd_d;

    always_comb begin
        rd_d = 32'd0;
        if (addr_i == ADDR_CTRL) begin
            rd_d[CTRL_RUN_BIT]       = ctrl_run_q;
            rd_d[CTRL_LOOP_BIT]      = ctrl_loop_q;
            rd_d[CTRL_LAST_LSB +: 3] = ctrl_last_q;
        end else if (addr_i == ADDR_STATUS) begin
            rd_d[STATUS_BUSY_BIT]     = (state_q == LOAD) || (state_q == HOLD);
            rd_d[STATUS_IDX_LSB +: 3] = idx_q;
            rd_d[STATUS_DONE_BIT]     = (state_q == DONE);
        end
`ifdef RGB_SEQ_READBACK_EN
        else if (addr_i[3] == ADDR_ENTRY_BASE[3]) begin
            rd_d[ENTRY_COLOR_LSB +: 3] = entry_q[addr_i[2:0]].color;
            rd_d[ENTRY_HOLD_LSB +: 8]  = entry_q[addr_i[2:0]].hold;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o <= 32'd0;
        end else begin
            data_o <= rd_d;
        end
    end

endmodule

// File: tb/tb_module_rgb_sequencer.sv
// tb_module_rgb_sequencer: directed bench for the RGB sequencer with TICK_DIV=4.
// Expected strobes (colour, edge number) are queued as stimulus is issued and
// matched by a monitor; register reads are compared in line.
module tb_module_rgb_sequencer;

    localparam int TD = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        we_i = 1'b0;
    logic [3:0]  addr_i = 4'd0;
    logic [31:0] data_i = 32'd0;
    logic [31:0] data_o;
    logic [2:0]  color_o;
    logic        color_we_o;

    module_rgb_sequencer #(
        .TICK_DIV (TD)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .data_o     (data_o),
        .color_o    (color_o),
        .color_we_o (color_we_o)
    );

    initial forever #5 clk_i = ~clk_i;

    int cyc = 0;   // number of rising edges so far
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0] col;
        int         at;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h, wanted 0x%0h (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Strobe monitor: sampled on the falling edge, a strobe seen here was
    // registered at rising edge number cyc.
    logic prev_we = 1'b0;
    always @(negedge clk_i) begin
        if (color_we_o === 1'b1) begin
            exp_t e;
            check("no_back_to_back", {31'd0, prev_we}, 32'd0);
            check("strobe_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("strobe_color", {29'd0, color_o}, {29'd0, e.col});
                check("strobe_edge", cyc, e.at);
            end
        end
        prev_we = (color_we_o === 1'b1);
    end

    task automatic wait_to(input int k);
        while (cyc < k) @(negedge clk_i);
    endtask

    // Write sampled at rising edge 'at'; returns on the falling edge after it.
    task automatic bus_wr(input int at, input logic [3:0] a, input logic [31:0] d);
        wait_to(at - 1);
        we_i   = 1'b1;
        addr_i = a;
        data_i = d;
        @(negedge clk_i);
        we_i   = 1'b0;
        addr_i = 4'd0;
        data_i = 32'd0;
    endtask

    task automatic expect_strobe(input logic [2:0] c, input int at);
        exp_t e;
        e.col = c;
        e.at  = at;
        exp_q.push_back(e);
    endtask

    task automatic read_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        @(negedge clk_i);
        addr_i = a;
        @(negedge clk_i);
        check(tag, data_o, exp);
        addr_i = 4'd0;
    endtask

    initial begin
        int t;
        logic [31:0] rb_exp;

        // ---- reset and idle ----
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst_color", {29'd0, color_o}, 32'd0);
        check("rst_we", {31'd0, color_we_o}, 32'd0);
        check("rst_data", data_o, 32'd0);
        rst_i = 1'b0;
        repeat (100) @(negedge clk_i);
        check("idle_color", {29'd0, color_o}, 32'd0);
        read_chk("idle_status", 4'd1, 32'd0);

        // ---- single entry, no loop ----
        bus_wr(cyc + 1, 4'd8, 32'h0000_0301);          // H=3 ROJO
        t = cyc + 1;
        bus_wr(t, 4'd0, 32'h0000_0001);
        expect_strobe(3'd1, t + 2);
        wait_to(t + 13);
        addr_i = 4'd1;
        @(negedge clk_i);
        check("single_status_busy", data_o, 32'h0000_0001);
        @(negedge clk_i);
        check("single_status_done", data_o, 32'h0000_0100);
        repeat (30) @(negedge clk_i);
        read_chk("single_status_later", 4'd1, 32'h0000_0100);

        // ---- loop of two entries, then stop ----
        bus_wr(cyc + 1, 4'd8, 32'h0000_0102);          // H=1 VERDE
        bus_wr(cyc + 1, 4'd9, 32'h0000_0203);          // H=2 AZUL
        t = cyc + 1;
        bus_wr(t, 4'd0, 32'h0000_0013);                // run, loop, last=1
        expect_strobe(3'd2, t + 2);
        expect_strobe(3'd3, t + 7);
        expect_strobe(3'd2, t + 16);
        expect_strobe(3'd3, t + 21);
        expect_strobe(3'd2, t + 30);
        bus_wr(t + 33, 4'd0, 32'h0000_0000);
        expect_strobe(3'd0, t + 34);
        repeat (20) @(negedge clk_i);
        read_chk("loop_stop_status", 4'd1, 32'd0);

        // ---- stop during HOLD of a BLANCO entry ----
        bus_wr(cyc + 1, 4'd8, 32'h0000_0507);          // H=5 BLANCO
        t = cyc + 1;
        bus_wr(t, 4'd0, 32'h0000_0001);
        expect_strobe(3'd7, t + 2);
        bus_wr(t + 8, 4'd0, 32'h0000_0000);
        expect_strobe(3'd0, t + 9);
        read_chk("stop_status", 4'd1, 32'd0);
        repeat (30) @(negedge clk_i);

        // ---- stop on the edge that emits the colour strobe ----
        t = cyc + 1;
        bus_wr(t, 4'd0, 32'h0000_0001);
        expect_strobe(3'd7, t + 2);
        bus_wr(t + 2, 4'd0, 32'h0000_0000);
        expect_strobe(3'd0, t + 4);
        repeat (20) @(negedge clk_i);
        read_chk("stop_early_status", 4'd1, 32'd0);

        // ---- restart colliding with hold expiry ----
        bus_wr(cyc + 1, 4'd8, 32'h0000_0102);          // H=1 VERDE
        bus_wr(cyc + 1, 4'd9, 32'h0000_0103);          // H=1 AZUL
        t = cyc + 1;
        bus_wr(t, 4'd0, 32'h0000_0011);                // run, last=1, no loop
        expect_strobe(3'd2, t + 2);
        bus_wr(t + 6, 4'd0, 32'h0000_0011);            // same edge as entry0 expiry
        expect_strobe(3'd2, t + 8);
        expect_strobe(3'd3, t + 13);
        repeat (20) @(negedge clk_i);
        read_chk("collide_status", 4'd1, 32'h0000_0110);

        // ---- reset during HOLD ----
        bus_wr(cyc + 1, 4'd8, 32'h0000_0507);
        t = cyc + 1;
        bus_wr(t, 4'd0, 32'h0000_0001);
        expect_strobe(3'd7, t + 2);
        wait_to(t + 5);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("midrst_color", {29'd0, color_o}, 32'd0);
        check("midrst_we", {31'd0, color_we_o}, 32'd0);
        check("midrst_data", data_o, 32'd0);
        rst_i = 1'b0;
        read_chk("midrst_ctrl", 4'd0, 32'd0);
        read_chk("midrst_status", 4'd1, 32'd0);
        repeat (30) @(negedge clk_i);

        // ---- index wrap with last=7, loop=1 ----
        for (int i = 0; i < 8; i++) begin
            bus_wr(cyc + 1, 4'(8 + i), 32'h0000_0100 | 32'(i));
        end
        t = cyc + 1;
        bus_wr(t, 4'd0, 32'h0000_0073);
        for (int k = 0; k < 10; k++) begin
            expect_strobe(3'(k % 8), t + 2 + 5 * k);
        end
        bus_wr(t + 49, 4'd0, 32'h0000_0000);
        expect_strobe(3'd0, t + 50);
        repeat (10) @(negedge clk_i);

        // ---- register map ----
        bus_wr(cyc + 1, 4'd0, 32'h0000_0070);          // last=7, not running
        bus_wr(cyc + 1, 4'd1, 32'hFFFF_FFFF);          // STATUS is read-only
        bus_wr(cyc + 1, 4'd2, 32'hFFFF_FFFF);          // unmapped
        read_chk("ctrl_readback", 4'd0, 32'h0000_0070);
        read_chk("status_ro", 4'd1, 32'd0);
        read_chk("unmapped_read", 4'd2, 32'd0);
        bus_wr(cyc + 1, 4'd13, 32'h0000_2A06);
`ifdef RGB_SEQ_READBACK_EN
        rb_exp = 32'h0000_2A06;
`else
        rb_exp = 32'd0;
`endif
        read_chk("entry5_read", 4'd13, rb_exp);
        repeat (20) @(negedge clk_i);

        check("all_strobes_seen", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/module_rgb_sequencer.md
# module_rgb_sequencer

Memory-mapped colour sequencer that sits directly upstream of the RGB LED driver peripheral. The CPU loads up to 8 (colour, hold-time) entries and a control word. The block then plays the sequence autonomously by issuing one-cycle colour write strobes (`color_o`/`color_we_o`) that connect straight to the LED driver's `color_i`/`we_i`. Colour codes use the LED driver's encoding: 0 OFF, 1 ROJO, 2 VERDE, 3 AZUL, 4 AMARILLO, 5 CIAN, 6 MAGENTA, 7 BLANCO.

## Interface
Parameters:
- `TICK_DIV`, default 10000: clock cycles per hold tick (1 ms at 10 MHz); must be ≥ 2.

Ports:
- `clk_i`  in  1  system clock
- `rst_i`  in  1  reset; one clock, synchronous, active-high
- `we_i`  in  1  bus write strobe; sampled at the rising edge
- `addr_i`  in  4  register address
- `data_i`  in  32  write data
- `data_o`  out  32  read data, registered
- `color_o`  out  3  colour to the LED driver
- `color_we_o`  out  1  one-cycle write strobe to the LED driver

## Operation
- Register map:
  - addr 0 CTRL (R/W): bit0 `run`, bit1 `loop`, bits[6:4] `last` (index of final entry, 0–7).
  - addr 1 STATUS (RO): bit0 `busy`, bits[6:4] current index, bit8 `done`.
  - addr 8–15 ENTRY[0–7] (R/W): bits[2:0] colour, bits[15:8] hold `H` in ticks, where H=0 is treated as 1.
  - Writes to addr 2–7 and to STATUS are ignored; reads of them return 0.
- FSM states: IDLE, LOAD, HOLD, DONE.
  - IDLE: outputs quiet. A CTRL write with run=1 → LOAD with index=0.
  - LOAD (one cycle): register `color_o`=ENTRY[idx].colour, pulse `color_we_o`, load the hold counter with H, clear the prescaler → HOLD.
  - HOLD: the prescaler counts to TICK_DIV−1 and emits a tick; each tick decrements the hold counter. When the counter reaches 0:
    - if idx≠last: idx+1 → LOAD;
    - if idx=last and loop=1: idx=0 → LOAD;
    - otherwise → DONE.
  - DONE: the last colour stays latched in the LED driver, done=1, busy=0. A CTRL write with run=1 restarts from index 0 → LOAD.
- A CTRL write with run=0 in any state → IDLE. It also emits one `color_we_o` pulse with `color_o`=0 (LED off), unless the block is already IDLE.
- A CTRL write with run=1 while in LOAD or HOLD restarts from index 0 with the new loop/last values.
- ENTRY writes are accepted in any state. They take effect the next time that entry is loaded. The entry currently playing is not re-emitted.
- `busy`=1 in LOAD and HOLD.

## Timing
- Reset values: `color_o`=0, `color_we_o`=0, `data_o`=0, CTRL=0, all entries 0, state IDLE, idx=0, prescaler and hold counter 0.
- Start latency: a CTRL write sampled at edge T causes `color_we_o` to be high for exactly the cycle between edges T+2 and T+3.
- Spacing: between successive `color_we_o` pulses, entry k occupies exactly max(H_k,1)·TICK_DIV + 1 cycles.
- `color_we_o` is never high on two consecutive cycles.
- Reads: `data_o` at edge T+1 reflects `addr_i` and register contents sampled at edge T (one-cycle read latency).
- Priority when events coincide in one cycle: `rst_i` > CTRL write > hold expiry.
- Reset mid-sequence clears everything in one edge and emits no strobe.
- Index wrap: idx is 3 bits. With last=7 and loop=1, idx goes 7 → 0 without gap beyond the normal LOAD cycle.

## Configuration
- `RGB_SEQ_READBACK_EN` defined: ENTRY registers are readable at addr 8–15.
- Not defined: reads of addr 8–15 return 0. Only CTRL and STATUS are readable, which removes the 8:1 read mux on entries. Write behaviour is identical in both builds.

## Structure
- Package `rgb_seq_pkg` holds:
  - the state enum (IDLE, LOAD, HOLD, DONE);
  - address constants ADDR_CTRL, ADDR_STATUS, ADDR_ENTRY_BASE;
  - CTRL/STATUS bit-position constants;
  - colour constants OFF…BLANCO, shared with the LED driver.
- One sub-module: `module_tick_prescaler`.
  - Parameter TICK_DIV; inputs `clk_i`, `rst_i`, `clr_i`; output `tick_o`.
  - `tick_o` is a one-cycle pulse every TICK_DIV cycles after `clr_i`.

## Test plan
- Reset then idle, TICK_DIV=4: no writes for 100 cycles → `color_we_o` never asserts, `color_o`=0, STATUS reads 0.
- Single entry, TICK_DIV=4: ENTRY0 = {H=3, ROJO}, CTRL run=1 last=0 loop=0 at edge T → one strobe with `color_o`=1 at T+2. STATUS reads done=1, busy=0 after 3·4+1 cycles, and no further strobes follow.
- Loop, TICK_DIV=4: entries {H=1 VERDE},{H=2 AZUL}, last=1, loop=1 → strobes with colours 2,3,2,3 at spacings 5,9,5,9 cycles.
- Stop mid-hold: during HOLD of a BLANCO entry, write CTRL=0 → exactly one strobe with `color_o`=0 and state IDLE (busy=0, done=0).
- Collision and restart: a CTRL run=1 write on the same cycle the hold expires → the next strobe is ENTRY0's colour, not idx+1's. Separately, assert `rst_i` mid-HOLD → no strobe, all outputs 0 next cycle.
- Readback, with `RGB_SEQ_READBACK_EN` defined: write ENTRY5=0x0000_2A06, then read addr 13 → `data_o`=0x0000_2A06 after one cycle. Without the macro, the same read returns 0.
